replace_policy_unit: RTL and testbench

REPLACE_POLICY_UNIT -- requirements
Module: replace_policy_unit

---
 rtl/replace_policy_unit.sv | 125 ++++++++++++
 tb/tb_replace_policy_unit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/replace_policy_unit.sv
// replace_policy_unit: per-set cache victim selection (LRU, random, FIFO, tree-PLRU) with registered one-hot response.
`ifndef CACHE_E
`define CACHE_E 4
`endif

module replace_policy_unit #(
    parameter int          SET_SIZE  = `CACHE_E,
    parameter int          NUM_SETS  = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         W         = $clog2(SET_SIZE),
    localparam int         SW        = NUM_SETS > 1 ? $clog2(NUM_SETS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                req_valid_i,
    input  logic [SW-1:0]       req_set_i,
    input  logic [1:0]          mode_i,
    input  logic [SET_SIZE-1:0] valid_line_i,
    input  logic [SET_SIZE-1:0] hit_line_i,
    input  logic [SET_SIZE-1:0] lock_line_i,
    output logic                resp_valid_o,
    output logic [SET_SIZE-1:0] way_o,
    output logic                evict_o,
    output logic                no_victim_o
);
    logic [W-1:0]        r_age [NUM_SETS][SET_SIZE];
    logic [W-1:0]        r_fifo [NUM_SETS];
    logic [SET_SIZE-2:0] r_plru [NUM_SETS];
    logic [15:0]         r_lfsr;
    logic                r_resp, r_evict, r_none;
    logic [SET_SIZE-1:0] r_way;

    logic                w_req, w_hit, w_free, w_none;
    logic [W-1:0]        w_hit_idx, w_free_idx, w_unl_idx, w_lru_idx, w_best;
    logic [W-1:0]        w_rnd_idx, w_fifo_idx, w_plru_idx, w_vic_idx, w_sel;
    logic [SET_SIZE-2:0] w_plru_nxt;
    int                  w_n, w_p;

    function automatic logic [W-1:0] next_unl(input logic [W-1:0] c, input logic [SET_SIZE-1:0] l);
        next_unl = c;
        for (int k = SET_SIZE - 1; k >= 0; k--)
            if (!l[c + W'(k)]) next_unl = c + W'(k);
    endfunction

    always_comb begin
        w_req      = req_valid_i && !flush_i;
        w_hit      = |hit_line_i;
        w_none     = !w_hit && (&lock_line_i);
        w_hit_idx  = '0;
        w_free_idx = '0;
        w_unl_idx  = '0;
        w_free     = 1'b0;
        for (int i = SET_SIZE - 1; i >= 0; i--) begin
            if (hit_line_i[i]) w_hit_idx = W'(i);
            if (!valid_line_i[i] && !lock_line_i[i]) begin
                w_free_idx = W'(i);
                w_free     = 1'b1;
            end
            if (!lock_line_i[i]) w_unl_idx = W'(i);
        end
        w_lru_idx = w_unl_idx;
        w_best    = r_age[req_set_i][w_unl_idx];
        for (int i = 0; i < SET_SIZE; i++)
            if (!lock_line_i[i] && r_age[req_set_i][i] > w_best) begin
                w_best    = r_age[req_set_i][i];
                w_lru_idx = W'(i);
            end
        w_rnd_idx  = next_unl(r_lfsr[W-1:0], lock_line_i);
        w_fifo_idx = next_unl(r_fifo[req_set_i], lock_line_i);
        // Heap-ordered tree walk: node n has children 2n and 2n+1, bit n-1 picks the right child.
        w_n = 1;
        for (int l = 0; l < W; l++) w_n = 2 * w_n + int'(r_plru[req_set_i][w_n-1]);
        w_plru_idx = W'(w_n - SET_SIZE);
        if (lock_line_i[w_plru_idx]) w_plru_idx = w_unl_idx;
        w_vic_idx = mode_i == 2'd0 ? w_lru_idx :
                    mode_i == 2'd1 ? w_rnd_idx :
                    mode_i == 2'd2 ? w_fifo_idx : w_plru_idx;
        w_sel = w_hit ? w_hit_idx : w_free ? w_free_idx : w_vic_idx;
        w_plru_nxt = r_plru[req_set_i];
        w_p = int'(w_sel) + SET_SIZE;
        for (int l = 0; l < W; l++) begin
            w_plru_nxt[(w_p >> 1) - 1] = ~w_p[0];
            w_p = w_p >> 1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_lfsr  <= LFSR_SEED;
            r_resp  <= 1'b0;
            r_way   <= '0;
            r_evict <= 1'b0;
            r_none  <= 1'b0;
        end else begin
            r_lfsr  <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
            r_resp  <= w_req;
            r_way   <= (w_req && !w_none) ? {{(SET_SIZE-1){1'b0}}, 1'b1} << w_sel : '0;
            r_evict <= w_req && !w_hit && !w_free && !w_none;
            r_none  <= w_req && w_none;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int i = 0; i < SET_SIZE; i++) r_age[s][i] <= W'(i);
                r_fifo[s] <= '0;
                r_plru[s] <= '0;
            end
        end else if (w_req && !w_none) begin
            for (int i = 0; i < SET_SIZE; i++)
                if (W'(i) == w_sel) r_age[req_set_i][i] <= '0;
                else if (r_age[req_set_i][i] < r_age[req_set_i][w_sel])
                    r_age[req_set_i][i] <= r_age[req_set_i][i] + W'(1);
            r_plru[req_set_i] <= w_plru_nxt;
            if (!w_hit) r_fifo[req_set_i] <= w_sel + W'(1);
        end
    end

    assign resp_valid_o = r_resp;
    assign way_o        = r_way;
    assign evict_o      = r_evict;
    assign no_victim_o  = r_none;
endmodule

// File: tb/tb_replace_policy_unit.sv
// tb_replace_policy_unit: directed checks of replace_policy_unit with SET_SIZE=4, NUM_SETS=2.
module tb_replace_policy_unit;
    logic       clk_i = 1'b0;
    logic       rst_ni, flush_i, req_valid_i;
    logic [0:0] req_set_i;
    logic [1:0] mode_i;
    logic [3:0] valid_line_i, hit_line_i, lock_line_i;
    logic       resp_valid_o, evict_o, no_victim_o;
    logic [3:0] way_o;
    int         checks = 0;
    int         errors = 0;

    localparam logic [1:0] LRU = 2'd0, RND = 2'd1, FIFO = 2'd2, PLRU = 2'd3;

    always #5 clk_i = ~clk_i;

    replace_policy_unit #(.SET_SIZE(4), .NUM_SETS(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .req_valid_i(req_valid_i),
        .req_set_i(req_set_i), .mode_i(mode_i), .valid_line_i(valid_line_i),
        .hit_line_i(hit_line_i), .lock_line_i(lock_line_i), .resp_valid_o(resp_valid_o),
        .way_o(way_o), .evict_o(evict_o), .no_victim_o(no_victim_o)
    );

    // Observed vector layout: {resp_valid, way[3:0], evict, no_victim}
    task automatic chk(input string tag, input logic [6:0] exp);
        logic [6:0] got;
        got = {resp_valid_o, way_o, evict_o, no_victim_o};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic s, input logic [1:0] m, input logic [3:0] v,
                        input logic [3:0] h, input logic [3:0] l, input logic f, input logic [6:0] exp);
        @(negedge clk_i);
        req_valid_i = 1'b1; req_set_i = s; mode_i = m;
        valid_line_i = v; hit_line_i = h; lock_line_i = l; flush_i = f;
        @(posedge clk_i); #1;
        chk(tag, exp);
    endtask

    task automatic idle(input string tag);
        @(negedge clk_i);
        req_valid_i = 1'b0; flush_i = 1'b0;
        @(posedge clk_i); #1;
        chk(tag, 7'b0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0; req_valid_i = 1'b0; flush_i = 1'b0;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; req_set_i = '0; mode_i = LRU;
        valid_line_i = '0; hit_line_i = '0; lock_line_i = '0;
        repeat (2) @(posedge clk_i);
        #1 chk("reset_state", 7'b0);
        @(negedge clk_i) rst_ni = 1'b1;

        step("fill_invalid", 0, LRU, 4'b1011, 4'b0000, 4'b0000, 0, 7'b1_0100_0_0);
        step("hit_multi_lock_ignored", 0, LRU, 4'b1111, 4'b0110, 4'b1111, 0, 7'b1_0010_0_0);
        idle("idle_no_resp");

        do_reset();
        step("lru_hit0", 0, LRU, 4'b1111, 4'b0001, 4'b0000, 0, 7'b1_0001_0_0);
        step("lru_hit1", 0, LRU, 4'b1111, 4'b0010, 4'b0000, 0, 7'b1_0010_0_0);
        step("lru_hit2", 0, LRU, 4'b1111, 4'b0100, 4'b0000, 0, 7'b1_0100_0_0);
        step("lru_hit3", 0, LRU, 4'b1111, 4'b1000, 4'b0000, 0, 7'b1_1000_0_0);
        step("lru_miss_set0", 0, LRU, 4'b1111, 4'b0000, 4'b0000, 0, 7'b1_0001_1_0);
        step("lru_miss_set1", 1, LRU, 4'b1111, 4'b0000, 4'b0000, 0, 7'b1_1000_1_0);

        do_reset();
        step("lru_locked_oldest", 0, LRU, 4'b1111, 4'b0000, 4'b1000, 0, 7'b1_0100_1_0);

        do_reset();
        step("fifo_m0", 0, FIFO, 4'b1111, 4'b0000, 4'b0000, 0, 7'b1_0001_1_0);
        step("fifo_m1", 0, FIFO, 4'b1111, 4'b0000, 4'b0000, 0, 7'b1_0010_1_0);
        step("fifo_m2", 0, FIFO, 4'b1111, 4'b0000, 4'b0000, 0, 7'b1_0100_1_0);
        step("fifo_m3", 0, FIFO, 4'b1111, 4'b0000, 4'b0000, 0, 7'b1_1000_1_0);
        step("fifo_m4_wrap", 0, FIFO, 4'b1111, 4'b0000, 4'b0000, 0, 7'b1_0001_1_0);

        do_reset();
        step("plru_m0", 0, PLRU, 4'b1111, 4'b0000, 4'b0000, 0, 7'b1_0001_1_0);
        step("plru_m1", 0, PLRU, 4'b1111, 4'b0000, 4'b0000, 0, 7'b1_0100_1_0);
        step("plru_m2", 0, PLRU, 4'b1111, 4'b0000, 4'b0000, 0, 7'b1_0010_1_0);
        step("plru_m3", 0, PLRU, 4'b1111, 4'b0000, 4'b0000, 0, 7'b1_1000_1_0);

        do_reset();
        step("plru_locked_leaf", 0, PLRU, 4'b1111, 4'b0000, 4'b0001, 0, 7'b1_0010_1_0);

        do_reset();
        step("fifo_lock0", 0, FIFO, 4'b1111, 4'b0000, 4'b0001, 0, 7'b1_0010_1_0);
        step("fifo_all_locked", 0, FIFO, 4'b1111, 4'b0000, 4'b1111, 0, 7'b1_0000_0_1);
        step("fifo_after_nolock", 0, FIFO, 4'b1111, 4'b0000, 4'b0000, 0, 7'b1_0100_1_0);

        step("rnd_one_unlocked0", 0, RND, 4'b1111, 4'b0000, 4'b1110, 0, 7'b1_0001_1_0);
        step("rnd_one_unlocked2", 1, RND, 4'b1111, 4'b0000, 4'b1011, 0, 7'b1_0100_1_0);

        do_reset();
        step("flush_prep_hit3", 0, LRU, 4'b1111, 4'b1000, 4'b0000, 0, 7'b1_1000_0_0);
        step("flush_drops_req", 0, LRU, 4'b1111, 4'b0000, 4'b0000, 1, 7'b0);
        step("lru_after_flush", 0, LRU, 4'b1111, 4'b0000, 4'b0000, 0, 7'b1_1000_1_0);

        @(negedge clk_i);
        rst_ni = 1'b0; req_valid_i = 1'b1; flush_i = 1'b0;
        @(posedge clk_i); #1;
        chk("reset_drops_req", 7'b0);
        @(negedge clk_i);
        rst_ni = 1'b1; req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        chk("no_resp_after_reset", 7'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
